// File: rtl/trs_io_port_bridge_if.sv
// Signal bundle between the TRS-80 I/O-port bridge and its surroundings:
// Z80 bus tap, window programming, ESP handshake and posted-write FIFO drain.
interface trs_io_port_bridge_if #(
    parameter int WIN_W   = 2,
    parameter int FIFO_AW = 3
);
    logic             io_start;
    logic             io_active;
    logic             io_is_in;
    logic [7:0]       io_addr;
    logic [7:0]       io_wdata;
    logic             cfg_we;
    logic [WIN_W-1:0] cfg_idx;
    logic [7:0]       cfg_base;
    logic [7:0]       cfg_mask;
    logic [1:0]       cfg_mode;
    logic             cfg_clr_to;
    logic             esp_done;
    logic             fifo_rd;
    logic [15:0]      fifo_dout;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             ext_io_sel;
    logic             wait_n_out;
    logic             esp_req;
    logic [WIN_W-1:0] esp_win;
    logic             esp_dir_in;
    logic             timeout_flag;

    modport slave (
        input  io_start, io_active, io_is_in, io_addr, io_wdata,
        input  cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_mode, cfg_clr_to,
        input  esp_done, fifo_rd,
        output fifo_dout, fifo_empty, fifo_count, ext_io_sel, wait_n_out,
        output esp_req, esp_win, esp_dir_in, timeout_flag
    );

    modport master (
        output io_start, io_active, io_is_in, io_addr, io_wdata,
        output cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_mode, cfg_clr_to,
        output esp_done, fifo_rd,
        input  fifo_dout, fifo_empty, fifo_count, ext_io_sel, wait_n_out,
        input  esp_req, esp_win, esp_dir_in, timeout_flag
    );
endinterface

// File: rtl/trs_io_port_bridge.sv
// Z80 I/O-port bridge: matches IN/OUT cycles against programmable windows and
// either stalls the Z80 until the ESP answers or posts OUT data into a FIFO.
module trs_io_port_bridge #(
    parameter int N_WIN      = 4,
    parameter int WIN_W      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int REQ_CYCLES = 50,
    parameter int TIMEOUT    = 2**20
) (
    input  logic                 clk,
    input  logic                 rst,
    trs_io_port_bridge_if.slave  bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(REQ_CYCLES + 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [7:0]       base_q [N_WIN];
    logic [7:0]       mask_q [N_WIN];
    logic [1:0]       mode_q [N_WIN];
    logic [15:0]      mem_q  [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
    logic [FIFO_AW:0] count_q;
    logic [2:0]       doneSync_q;
    logic             wait_q, req_q, dirIn_q, timeout_q;
    logic [WIN_W-1:0] win_q;
    logic [RC_W-1:0]  reqCnt_q;
    logic [TO_W-1:0]  waitCnt_q;

    logic             anyHit;
    logic [WIN_W-1:0] hitIdx;
    logic [1:0]       hitMode;
    logic             popEn, pushEn, startBlock, accept, ignoreIn, doneEdge, fifoFull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WIN; i++) begin
                base_q[i] <= 8'h00;
                mask_q[i] <= 8'h00;
                mode_q[i] <= 2'b00;
            end
        end else if (bus.cfg_we) begin
            base_q[bus.cfg_idx] <= bus.cfg_base;
            mask_q[bus.cfg_idx] <= bus.cfg_mask;
            mode_q[bus.cfg_idx] <= bus.cfg_mode;
        end
    end

    // Scan from the top so the lowest-numbered matching window is what remains.
    always_comb begin
        anyHit  = 1'b0;
        hitIdx  = '0;
        hitMode = 2'b00;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (mode_q[i] != 2'b00 && ((bus.io_addr ^ base_q[i]) & mask_q[i]) == 8'h00) begin
                anyHit  = 1'b1;
                hitIdx  = WIN_W'(i);
                hitMode = mode_q[i];
            end
        end
    end

    assign fifoFull   = (count_q == DEPTH_C);
    assign popEn      = bus.fifo_rd && (count_q != '0);
    assign accept     = (state_q == IDLE) && bus.io_start && anyHit;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign pushEn     = accept && !bus.io_is_in && hitMode[1] && (!fifoFull || popEn);
    assign ignoreIn   = bus.io_is_in && (hitMode == 2'b10);
    assign startBlock = accept && !pushEn && !ignoreIn;
    assign doneEdge   = doneSync_q[1] && !doneSync_q[2];

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= {8'(hitIdx), bus.io_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
            if (popEn)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            doneSync_q <= 3'b000;
        end else begin
            doneSync_q <= {doneSync_q[1:0], bus.esp_done};
        end
    end

    // Clearing the timeout flag is placed first so a same-cycle timeout overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 1'b0;
            req_q     <= 1'b0;
            win_q     <= '0;
            dirIn_q   <= 1'b0;
            timeout_q <= 1'b0;
            reqCnt_q  <= '0;
            waitCnt_q <= '0;
        end else begin
            if (bus.cfg_clr_to) timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startBlock) begin
                        wait_q    <= 1'b1;
                        req_q     <= 1'b1;
                        win_q     <= hitIdx;
                        dirIn_q   <= bus.io_is_in;
                        reqCnt_q  <= '0;
                        waitCnt_q <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (doneEdge) begin
                        wait_q  <= 1'b0;
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (waitCnt_q == TO_W'(TIMEOUT - 1)) begin
                        wait_q    <= 1'b0;
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                        if (req_q) begin
                            if (reqCnt_q == RC_W'(REQ_CYCLES - 1)) req_q <= 1'b0;
                            else reqCnt_q <= reqCnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_dout    = (count_q == '0) ? 16'h0000 : mem_q[rdPtr_q];
    assign bus.fifo_empty   = (count_q == '0);
    assign bus.fifo_count   = count_q;
    assign bus.ext_io_sel   = bus.io_active && anyHit;
    assign bus.wait_n_out   = wait_q;
    assign bus.esp_req      = req_q;
    assign bus.esp_win      = win_q;
    assign bus.esp_dir_in   = dirIn_q;
    assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_trs_io_port_bridge.sv
// Self-checking bench for trs_io_port_bridge: blocking and posted cycles,
// window priority, FIFO full fallback, timeout and asynchronous reset.
module tb_trs_io_port_bridge;
    localparam int TO_CYC  = 300;
    localparam int REQ_CYC = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    logic [15:0] expQ[$];

    trs_io_port_bridge_if #(.WIN_W(2), .FIFO_AW(3)) bus();

    trs_io_port_bridge #(
        .N_WIN(4), .WIN_W(2), .FIFO_DEPTH(8), .FIFO_AW(3),
        .REQ_CYCLES(REQ_CYC), .TIMEOUT(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setWin(input logic [1:0] idx, input logic [7:0] base,
                          input logic [7:0] mask, input logic [1:0] mode);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_base = base;
        bus.cfg_mask = mask; bus.cfg_mode = mode;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // Ends at the negedge right after the io_start edge.
    task automatic busOp(input logic isIn, input logic [7:0] addr,
                         input logic [7:0] data, input logic pop);
        @(negedge clk);
        bus.io_start = 1'b1; bus.io_active = 1'b1; bus.io_is_in = isIn;
        bus.io_addr = addr; bus.io_wdata = data; bus.fifo_rd = pop;
        @(negedge clk);
        bus.io_start = 1'b0; bus.io_active = 1'b0; bus.fifo_rd = 1'b0;
    endtask

    task automatic doneRelease(output int n);
        bus.esp_done = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wait_n_out && n < 20);
        bus.esp_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [24:0] obs, exp;
        @(negedge clk);
        obs = {bus.wait_n_out, bus.esp_req, bus.fifo_empty, bus.fifo_count, bus.timeout_flag,
               bus.esp_win, bus.esp_dir_in, bus.fifo_dout, bus.ext_io_sel};
        exp = {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_blocking_in();
        int n;
        setWin(2'd0, 8'h1F, 8'hFF, 2'b01);
        busOp(1'b1, 8'h1F, 8'h00, 1'b0);
        total++;
        if ({bus.wait_n_out, bus.esp_req, bus.esp_win, bus.esp_dir_in} !== {1'b1, 1'b1, 2'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL blk_start: wait/req/win/dir got %b%b%0d%b expected 1101",
                     bus.wait_n_out, bus.esp_req, bus.esp_win, bus.esp_dir_in);
        end
        n = 0;
        while (bus.esp_req && n < 200) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != REQ_CYC || bus.wait_n_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL blk_req_len: got %0d cycles wait=%b expected %0d wait=1", n, bus.wait_n_out, REQ_CYC);
        end
        doneRelease(n);
        total++;
        if (n != 3 || bus.wait_n_out !== 1'b0 || bus.esp_win !== 2'd0 || bus.esp_dir_in !== 1'b1) begin
            bad++;
            $display("[TB] FAIL blk_done_latency: got %0d wait=%b win=%0d dir=%b expected 3 0 0 1",
                     n, bus.wait_n_out, bus.esp_win, bus.esp_dir_in);
        end
    endtask

    task automatic test_posted();
        logic [15:0] e;
        setWin(2'd1, 8'hC0, 8'hF0, 2'b10);
        busOp(1'b0, 8'hC5, 8'hA5, 1'b0);
        expQ.push_back(16'h01A5);
        total++;
        if ({bus.wait_n_out, bus.esp_req} !== 2'b00 || bus.fifo_count !== 4'd1 || bus.fifo_dout !== expQ[0]) begin
            bad++;
            $display("[TB] FAIL posted_out: wait=%b req=%b count=%0d dout=%h expected 0 0 1 %h",
                     bus.wait_n_out, bus.esp_req, bus.fifo_count, bus.fifo_dout, expQ[0]);
        end
        busOp(1'b1, 8'hC5, 8'h00, 1'b0);
        total++;
        if (bus.wait_n_out !== 1'b0 || bus.fifo_count !== 4'd1) begin
            bad++;
            $display("[TB] FAIL posted_mode_in_ignored: wait=%b count=%0d expected 0 1", bus.wait_n_out, bus.fifo_count);
        end
        e = expQ.pop_front();
        total++;
        if (bus.fifo_dout !== e) begin
            bad++;
            $display("[TB] FAIL posted_drain: got %h expected %h", bus.fifo_dout, e);
        end
        bus.fifo_rd = 1'b1;
        @(negedge clk);
        bus.fifo_rd = 1'b0;
        bus.fifo_rd = 1'b1;
        @(negedge clk);
        bus.fifo_rd = 1'b0;
        total++;
        if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== 4'd0) begin
            bad++;
            $display("[TB] FAIL pop_empty: empty=%b count=%0d expected 1 0", bus.fifo_empty, bus.fifo_count);
        end
    endtask

    task automatic fillFifo();
        for (int i = 0; i < 8; i++) begin
            busOp(1'b0, 8'hC0 + 8'(i), 8'(i * 17 + 3), 1'b0);
            expQ.push_back({8'h01, 8'(i * 17 + 3)});
        end
    endtask

    task automatic test_fifo_full();
        int n;
        logic [15:0] e;
        fillFifo();
        total++;
        if (bus.fifo_count !== 4'd8 || bus.wait_n_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_8: count=%0d wait=%b expected 8 0", bus.fifo_count, bus.wait_n_out);
        end
        busOp(1'b0, 8'hCF, 8'h99, 1'b0);
        total++;
        if ({bus.wait_n_out, bus.esp_win, bus.esp_dir_in} !== {1'b1, 2'd1, 1'b0} || bus.fifo_count !== 4'd8) begin
            bad++;
            $display("[TB] FAIL full_blocks: wait=%b win=%0d dir=%b count=%0d expected 1 1 0 8",
                     bus.wait_n_out, bus.esp_win, bus.esp_dir_in, bus.fifo_count);
        end
        e = expQ.pop_front();
        total++;
        if (bus.fifo_dout !== e) begin
            bad++;
            $display("[TB] FAIL full_head: got %h expected %h", bus.fifo_dout, e);
        end
        bus.fifo_rd = 1'b1;
        @(negedge clk);
        bus.fifo_rd = 1'b0;
        doneRelease(n);
        total++;
        if (bus.fifo_count !== 4'd7 || bus.wait_n_out !== 1'b0 || bus.esp_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_release: count=%0d wait=%b req=%b expected 7 0 0",
                     bus.fifo_count, bus.wait_n_out, bus.esp_req);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            total++;
            if (bus.fifo_dout !== e) begin
                bad++;
                $display("[TB] FAIL drain_entry: got %h expected %h", bus.fifo_dout, e);
            end
            bus.fifo_rd = 1'b1;
            @(negedge clk);
            bus.fifo_rd = 1'b0;
        end
        total++;
        if (bus.fifo_empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drain_empty: got %b expected 1", bus.fifo_empty);
        end
    endtask

    task automatic test_priority();
        int n;
        setWin(2'd0, 8'h1F, 8'hFF, 2'b01);
        setWin(2'd1, 8'h10, 8'hF0, 2'b01);
        busOp(1'b1, 8'h1F, 8'h00, 1'b0);
        total++;
        if (bus.wait_n_out !== 1'b1 || bus.esp_win !== 2'd0) begin
            bad++;
            $display("[TB] FAIL prio_win0: wait=%b win=%0d expected 1 0", bus.wait_n_out, bus.esp_win);
        end
        doneRelease(n);
        busOp(1'b1, 8'h15, 8'h00, 1'b0);
        total++;
        if (bus.wait_n_out !== 1'b1 || bus.esp_win !== 2'd1) begin
            bad++;
            $display("[TB] FAIL prio_win1: wait=%b win=%0d expected 1 1", bus.wait_n_out, bus.esp_win);
        end
        doneRelease(n);
        bus.io_active = 1'b1; bus.io_addr = 8'h80;
        #1;
        total++;
        if (bus.ext_io_sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sel_miss: got %b expected 0", bus.ext_io_sel);
        end
        bus.io_addr = 8'h15;
        #1;
        total++;
        if (bus.ext_io_sel !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sel_hit: got %b expected 1", bus.ext_io_sel);
        end
        bus.io_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        busOp(1'b1, 8'h1F, 8'h00, 1'b0);
        n = 0;
        while (bus.wait_n_out && n < 1000) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != TO_CYC || bus.timeout_flag !== 1'b1 || bus.esp_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout: got %0d cycles flag=%b req=%b expected %0d 1 0",
                     n, bus.timeout_flag, bus.esp_req, TO_CYC);
        end
        bus.cfg_clr_to = 1'b1;
        @(negedge clk);
        bus.cfg_clr_to = 1'b0;
        total++;
        if (bus.timeout_flag !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_clear: got %b expected 0", bus.timeout_flag);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        setWin(2'd1, 8'hC0, 8'hF0, 2'b10);
        fillFifo();
        busOp(1'b0, 8'hC3, 8'h5A, 1'b1);
        e = expQ.pop_front();
        expQ.push_back(16'h015A);
        total++;
        if (bus.fifo_count !== 4'd8 || bus.wait_n_out !== 1'b0 || bus.fifo_dout !== expQ[0]) begin
            bad++;
            $display("[TB] FAIL push_pop_full: count=%0d wait=%b dout=%h expected 8 0 %h",
                     bus.fifo_count, bus.wait_n_out, bus.fifo_dout, expQ[0]);
        end
        busOp(1'b1, 8'h1F, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.wait_n_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_before_rst: got %b expected 1", bus.wait_n_out);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.wait_n_out, bus.esp_req, bus.fifo_count, bus.fifo_empty, bus.timeout_flag} !== {2'b00, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL async_rst: wait=%b req=%b count=%0d empty=%b flag=%b expected 0 0 0 1 0",
                     bus.wait_n_out, bus.esp_req, bus.fifo_count, bus.fifo_empty, bus.timeout_flag);
        end
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.io_active = 1'b1; bus.io_addr = 8'h1F;
        #1;
        total++;
        if (bus.ext_io_sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL windows_cleared: got %b expected 0", bus.ext_io_sel);
        end
        bus.io_active = 1'b0;
    endtask

    initial begin
        bus.io_start = 1'b0; bus.io_active = 1'b0; bus.io_is_in = 1'b0;
        bus.io_addr = 8'h00; bus.io_wdata = 8'h00;
        bus.cfg_we = 1'b0; bus.cfg_idx = 2'd0; bus.cfg_base = 8'h00;
        bus.cfg_mask = 8'h00; bus.cfg_mode = 2'b00; bus.cfg_clr_to = 1'b0;
        bus.esp_done = 1'b0; bus.fifo_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_blocking_in();
        test_posted();
        test_fifo_full();
        test_priority();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
